slower_clk: RTL and testbench
=============================

SLOWER_CLK -- requirements
Module: slower_clk

Interface
REQ-001 Parameter DIV, default 2: half-period of clk_slow, counted in clk rising edges; integer >= 1.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clk_slow  output  1  divided clock, registered, 50% duty, period 2*DIV clk cycles.

Function
REQ-005 The module SHALL hold an internal counter of width max(1, ceil(log2(DIV))) bits, unsigned, counting clk rising edges.
REQ-006 When rst is low at a rising edge and counter < DIV-1, the module SHALL increment counter by 1 and hold clk_slow.
REQ-007 When rst is low at a rising edge and counter == DIV-1, the module SHALL clear counter to 0 and invert clk_slow in the same edge.
REQ-008 clk_slow SHALL be driven directly from a flip-flop: no combinational path from clk or rst, no glitches.
REQ-009 The first clk_slow rise after reset release SHALL occur on the DIV-th rising edge with rst low; the following fall SHALL occur DIV edges later; the pattern SHALL repeat indefinitely.
REQ-010 clk_slow SHALL be high for exactly DIV clk cycles and low for exactly DIV clk cycles in every period; duty error zero for every legal DIV, odd or even.
REQ-011 DIV = 1 SHALL give clk_slow toggling on every rising edge (period 2 clk cycles); counter then stays at 0.
REQ-012 The counter SHALL never exceed DIV-1; no wrap-around through the full counter width is permitted.
REQ-013 Elaboration with DIV < 1 SHALL be rejected with a compile-time error.
REQ-014 clk_slow is a data-path signal derived in the clk domain; downstream logic SHALL use it as an enable or sample it, and the spec makes no clock-tree guarantees for it.

Reset
REQ-015 rst high at a rising edge SHALL set counter to 0 and clk_slow to 0, overriding REQ-006/REQ-007 in that cycle.
REQ-016 rst asserted mid-period, including on the edge where a toggle would occur, SHALL force clk_slow to 0 and counter to 0; counting restarts from 0 on the first edge with rst low.
REQ-017 Before the first rising edge with rst high, output value is undefined; benches SHALL hold rst high for at least one rising edge.
REQ-018 rst held high for many cycles SHALL keep clk_slow at 0 and counter at 0 throughout.

Verification
REQ-019 DIV=2, clk period 4 ns, rst high for 10 ns then low -> clk_slow 0 during reset; rises on the 2nd edge after release; period 16 ns (4 clk cycles), high 8 ns, low 8 ns, for 1000 ns.
REQ-020 DIV=1 -> after reset, clk_slow toggles every edge: 0,1,0,1..., period 2 clk cycles.
REQ-021 DIV=3 (odd) -> high exactly 3 cycles, low exactly 3 cycles, period 6 cycles, first rise on the 3rd edge after release.
REQ-022 DIV=2, rst pulsed high for one edge while clk_slow=1 mid-period -> clk_slow 0 on that edge; next rise exactly 2 edges after rst drops.
REQ-023 DIV=5, rst asserted on the exact edge where counter==4 -> no toggle, clk_slow=0, counter=0; next rise 5 edges after release.
REQ-024 Any DIV, long run (>= 100 periods) -> count of clk_slow rising edges equals floor(edges_since_release / (2*DIV)) +/- 1; no missing or extra toggles.

Source files
------------

// File: rtl/slower_clk_if.sv
// Carries the divided clock from slower_clk to downstream logic.
// Consumers should treat clk_slow as an enable or a sampled signal, not as a clock.
interface slower_clk_if;
  logic clk_slow;

  modport master (output clk_slow);
  modport slave  (input  clk_slow);
endinterface

// File: rtl/slower_clk.sv
// Divides clk by 2*DIV. The output is a 50% duty square wave driven straight from a flop.
// The counter runs 0..DIV-1, and clk_slow toggles on the edge where it wraps.
module slower_clk #(
  parameter int DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  slower_clk_if.master  out_if
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("slower_clk: DIV must be >= 1");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic          slow_q, slow_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    slow_d = slow_q;
    if (cnt_q == TC) begin
      cnt_d  = '0;
      slow_d = ~slow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slow_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slow_q <= slow_d;
    end
  end

  assign out_if.clk_slow = slow_q;

endmodule

// File: tb/tb_slower_clk.sv
// Self-checking bench for slower_clk at DIV = 1, 2, 3 and 5, run side by side on one clock.
// The reference model predicts clk_slow from the number of edges seen since reset released.
module tb_slower_clk;

  localparam int N = 4;
  localparam int DIVS [N] = '{1, 2, 3, 5};

  logic         clk = 1'b0;
  logic [N-1:0] rst_v = '1;
  logic [N-1:0] slow;
  int           k [N];
  int           checks = 0;
  int           failures = 0;

  always #2 clk = ~clk;

  slower_clk_if if0 ();
  slower_clk_if if1 ();
  slower_clk_if if2 ();
  slower_clk_if if3 ();

  slower_clk #(.DIV(1)) u_div1 (.clk(clk), .rst(rst_v[0]), .out_if(if0.master));
  slower_clk #(.DIV(2)) u_div2 (.clk(clk), .rst(rst_v[1]), .out_if(if1.master));
  slower_clk #(.DIV(3)) u_div3 (.clk(clk), .rst(rst_v[2]), .out_if(if2.master));
  slower_clk #(.DIV(5)) u_div5 (.clk(clk), .rst(rst_v[3]), .out_if(if3.master));

  assign slow[0] = if0.clk_slow;
  assign slow[1] = if1.clk_slow;
  assign slow[2] = if2.clk_slow;
  assign slow[3] = if3.clk_slow;

  // k[i] = number of rising edges with rst low since the last edge with rst high
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_v[i]) k[i] <= 0;
      else          k[i] <= k[i] + 1;
    end
  end

  function automatic logic exp_slow(input int i);
    return ((k[i] / DIVS[i]) % 2) == 1;
  endfunction

  task automatic test_reset();
    rst_v = '1;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (slow[i] !== 1'b0) begin
          failures++;
          $display("FAIL reset_hold div=%0d got=%b exp=0", DIVS[i], slow[i]);
        end
      end
    end
  endtask

  task automatic test_free_run();
    int first_rise [N];
    int run_len [N];
    int runs_seen [N];
    logic prev [N];
    for (int i = 0; i < N; i++) begin
      first_rise[i] = -1; run_len[i] = 0; runs_seen[i] = 0; prev[i] = 1'b0;
    end
    rst_v = '0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (slow[i] !== exp_slow(i)) begin
          failures++;
          $display("FAIL free_run div=%0d cyc=%0d got=%b exp=%b", DIVS[i], cyc, slow[i], exp_slow(i));
        end
        if (slow[i] === 1'b1 && first_rise[i] < 0) first_rise[i] = cyc;
        if (slow[i] !== prev[i]) begin
          // The first low stretch includes reset time, so only later runs are measured.
          if (runs_seen[i] > 0) begin
            checks++;
            if (run_len[i] != DIVS[i]) begin
              failures++;
              $display("FAIL duty_run div=%0d cyc=%0d got=%0d exp=%0d", DIVS[i], cyc, run_len[i], DIVS[i]);
            end
          end
          runs_seen[i]++;
          run_len[i] = 1;
          prev[i] = slow[i];
        end else begin
          run_len[i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (first_rise[i] != DIVS[i]) begin
        failures++;
        $display("FAIL first_rise div=%0d got=%0d exp=%0d", DIVS[i], first_rise[i], DIVS[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    int edges;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    while (slow[1] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (slow[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_wait div=2 got=%b exp=1", slow[1]);
    end
    rst_v[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (slow[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_force div=2 got=%b exp=0", slow[1]);
    end
    rst_v[1] = 1'b0;
    edges = 0;
    while (edges < 10) begin
      @(negedge clk);
      edges++;
      if (slow[1] === 1'b1) break;
    end
    checks++;
    if (edges != 2 || slow[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_rise div=2 got=%0d edges exp=2", edges);
    end
  endtask

  task automatic test_tc_reset();
    int waited = 0;
    int edges;
    // k % 10 == 4 means the DIV=5 counter sits at 4 and clk_slow is about to rise
    while ((k[3] % 10) != 4 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if ((k[3] % 10) != 4 || slow[3] !== 1'b0) begin
      failures++;
      $display("FAIL tc_reset_wait div=5 got=%b k=%0d exp=0 k%%10=4", slow[3], k[3]);
    end
    rst_v[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (slow[3] !== 1'b0) begin
      failures++;
      $display("FAIL tc_reset_notoggle div=5 got=%b exp=0", slow[3]);
    end
    rst_v[3] = 1'b0;
    edges = 0;
    while (edges < 12) begin
      @(negedge clk);
      edges++;
      if (slow[3] === 1'b1) break;
    end
    checks++;
    if (edges != 5 || slow[3] !== 1'b1) begin
      failures++;
      $display("FAIL tc_reset_rise div=5 got=%0d edges exp=5", edges);
    end
  endtask

  task automatic test_random_resets();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (slow[i] !== exp_slow(i)) begin
          failures++;
          $display("FAIL random_reset div=%0d cyc=%0d got=%b exp=%b", DIVS[i], cyc, slow[i], exp_slow(i));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rst_v[i]) rst_v[i] = ($urandom_range(0, 2) == 0);
        else          rst_v[i] = ($urandom_range(0, 39) == 0);
      end
    end
  endtask

  task automatic test_long_run();
    int rises [N];
    logic prev [N];
    int expd;
    rst_v = '1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rises[i] = 0;
      prev[i] = slow[i];
    end
    rst_v = '0;
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (prev[i] === 1'b0 && slow[i] === 1'b1) rises[i]++;
        prev[i] = slow[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      expd = 1200 / (2 * DIVS[i]);
      checks++;
      if (rises[i] < expd - 1 || rises[i] > expd + 1) begin
        failures++;
        $display("FAIL long_run_rises div=%0d got=%0d exp=%0d", DIVS[i], rises[i], expd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mid_reset();
    test_tc_reset();
    test_random_resets();
    test_reset();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
